// File: rtl/ldtu_mode_sequencer.sv
// ldtu_mode_sequencer: operating-mode controller for the LiTE-DTU 160 MHz datapath.
// Sequences hold-reset, calibration, ATU test passthrough and DTU run, and drains
// the output FIFO before leaving RUN so frame streams are never truncated.
// Optional feature macro: LDTU_ORBIT_ALIGN_EN (adds WAIT_ORBIT so RUN starts on an
// orbit boundary). Default build: feature disabled, orbit input unused.
//
// state      | code | meaning
// -----------+------+-----------------------------------------------------
// RESET      |  0   | datapath held in reset for RST_HOLD cycles
// RUN        |  1   | normal DTU encoding
// DRAIN      |  2   | encoder stopped, waiting for output FIFO to empty
// CALIB      |  3   | calibration in progress, datapath held in reset
// TEST       |  4   | ATU passthrough selected, datapath held in reset
// WAIT_ORBIT |  5   | datapath released, waiting for orbit (feature only)
// 6..7       |  -   | illegal, recover to RESET

module ldtu_mode_sequencer #(
  parameter int RST_HOLD      = 4,
  parameter int DRAIN_TIMEOUT = 64,
  parameter int CNT_BITS      = 7
) (
  input  logic       CLK,
  input  logic       rst_b,
  input  logic       calib_busy,
  input  logic       test_enable,
  input  logic       fifo_empty,
  input  logic       orbit,
  output logic       dp_rst_b,
  output logic       enc_enable,
  output logic       sel_atu,
  output logic [2:0] state_o,
  output logic       drain_timeout
);

  typedef enum logic [2:0] {
    S_RESET      = 3'd0,
    S_RUN        = 3'd1,
    S_DRAIN      = 3'd2,
    S_CALIB      = 3'd3,
    S_TEST       = 3'd4,
    S_WAIT_ORBIT = 3'd5
  } state_t;

  localparam logic [CNT_BITS-1:0] HOLD_LAST  = CNT_BITS'(RST_HOLD - 1);
  localparam logic [CNT_BITS-1:0] DRAIN_LAST = CNT_BITS'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX    = '1;

`ifdef LDTU_ORBIT_ALIGN_EN
  localparam state_t RUN_ENTRY = S_WAIT_ORBIT;
`else
  localparam state_t RUN_ENTRY = S_RUN;
  logic unused_orbit;
  assign unused_orbit = orbit;
`endif

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                dto_q, dto_d;

  // Request priority: calibration beats test, which beats the fallback target.
  function automatic state_t pick_target(input logic cb, input logic te,
                                         input state_t fallback);
    if (cb)      return S_CALIB;
    else if (te) return S_TEST;
    else         return fallback;
  endfunction

  // State, shared hold/drain counter and sticky timeout flag.
  always_ff @(posedge CLK) begin
    if (!rst_b) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
      dto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dto_q   <= dto_d;
    end
  end

  // Next-state, counter and sticky flag update.
  always_comb begin
    state_d = state_q;
    dto_d   = dto_q;
    case (state_q)
      S_RESET: begin
        if (cnt_q == HOLD_LAST) state_d = pick_target(calib_busy, test_enable, RUN_ENTRY);
      end
      S_RUN: begin
        if (calib_busy || test_enable) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (fifo_empty) begin
          state_d = pick_target(calib_busy, test_enable, S_RESET);
        end else if (cnt_q == DRAIN_LAST) begin
          state_d = pick_target(calib_busy, test_enable, S_RESET);
          dto_d   = 1'b1;
        end
      end
      S_CALIB: begin
        if (!calib_busy) state_d = S_RESET;
      end
      S_TEST: begin
        if (calib_busy)        state_d = S_CALIB;
        else if (!test_enable) state_d = S_RESET;
      end
`ifdef LDTU_ORBIT_ALIGN_EN
      S_WAIT_ORBIT: begin
        if (calib_busy || test_enable) state_d = pick_target(calib_busy, test_enable, S_RESET);
        else if (orbit)                state_d = S_RUN;
      end
`endif
      default: state_d = S_RESET;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == S_RESET || state_q == S_DRAIN) && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Moore output decode from the registered state; illegal codes look like RESET.
  always_comb begin
    dp_rst_b   = 1'b0;
    enc_enable = 1'b0;
    sel_atu    = 1'b0;
    case (state_q)
      S_RUN: begin
        dp_rst_b   = 1'b1;
        enc_enable = 1'b1;
      end
      S_DRAIN: dp_rst_b = 1'b1;
      S_TEST:  sel_atu  = 1'b1;
`ifdef LDTU_ORBIT_ALIGN_EN
      S_WAIT_ORBIT: dp_rst_b = 1'b1;
`endif
      default: ;
    endcase
  end

  assign state_o       = state_q;
  assign drain_timeout = dto_q;

endmodule

// File: tb/tb_ldtu_mode_sequencer.sv
// Scoreboard bench for ldtu_mode_sequencer: directed bring-up/drain/priority/reset
// scenarios followed by randomized request traffic, checked cycle by cycle against
// a mode/elapsed-time reference model.

module tb_ldtu_mode_sequencer;

  localparam int RST_HOLD      = 4;
  localparam int DRAIN_TIMEOUT = 64;

  localparam int M_RESET = 0, M_RUN = 1, M_DRAIN = 2, M_CALIB = 3, M_TEST = 4, M_WAIT = 5;

  logic       CLK = 1'b0;
  logic       rst_b = 1'b0;
  logic       calib_busy = 1'b0;
  logic       test_enable = 1'b0;
  logic       fifo_empty = 1'b0;
  logic       orbit = 1'b0;
  logic       dp_rst_b, enc_enable, sel_atu, drain_timeout;
  logic [2:0] state_o;

  ldtu_mode_sequencer #(
    .RST_HOLD(RST_HOLD), .DRAIN_TIMEOUT(DRAIN_TIMEOUT), .CNT_BITS(7)
  ) dut (
    .CLK(CLK), .rst_b(rst_b), .calib_busy(calib_busy), .test_enable(test_enable),
    .fifo_empty(fifo_empty), .orbit(orbit), .dp_rst_b(dp_rst_b),
    .enc_enable(enc_enable), .sel_atu(sel_atu), .state_o(state_o),
    .drain_timeout(drain_timeout)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit stim_done = 1'b0;

  // expected {state[2:0], dp_rst_b, enc_enable, sel_atu, drain_timeout}
  logic [6:0] exp_q[$];

  // Reference model: current mode, how long we have been in it, sticky flag.
  int m_mode  = M_RESET;
  int m_dwell = 0;
  bit m_flag  = 1'b0;

  function automatic int requested(input bit cb, input bit te, input int otherwise);
    if (cb) return M_CALIB;
    if (te) return M_TEST;
    return otherwise;
  endfunction

  function automatic logic [6:0] mode_outputs(input int mode, input bit flag);
    logic [2:0] code;
    logic       dp, en, sel;
    code = 3'(mode);
    dp = (mode == M_RUN) || (mode == M_DRAIN) || (mode == M_WAIT);
    en = (mode == M_RUN);
    sel = (mode == M_TEST);
    return {code, dp, en, sel, flag};
  endfunction

  task automatic model_step(input bit r, input bit cb, input bit te, input bit fe, input bit orb);
    int nxt;
    if (!r) begin
      m_mode = M_RESET; m_dwell = 0; m_flag = 1'b0;
      return;
    end
    nxt = m_mode;
    if (m_mode == M_RESET) begin
      // hold lasts RST_HOLD cycles, then go where the requests point
      if (m_dwell + 1 >= RST_HOLD) begin
`ifdef LDTU_ORBIT_ALIGN_EN
        nxt = requested(cb, te, M_WAIT);
`else
        nxt = requested(cb, te, M_RUN);
`endif
      end
    end else if (m_mode == M_RUN) begin
      if (cb || te) nxt = M_DRAIN;
    end else if (m_mode == M_DRAIN) begin
      if (fe) nxt = requested(cb, te, M_RESET);
      else if (m_dwell + 1 >= DRAIN_TIMEOUT) begin
        nxt = requested(cb, te, M_RESET);
        m_flag = 1'b1;
      end
    end else if (m_mode == M_CALIB) begin
      if (!cb) nxt = M_RESET;
    end else if (m_mode == M_TEST) begin
      if (cb) nxt = M_CALIB;
      else if (!te) nxt = M_RESET;
    end else if (m_mode == M_WAIT) begin
      if (cb || te) nxt = requested(cb, te, M_RESET);
      else if (orb) nxt = M_RUN;
    end
    m_dwell = (nxt == m_mode) ? m_dwell + 1 : 0;
    m_mode  = nxt;
  endtask

  // One clock of stimulus: drive on the falling edge, predict the post-edge outputs.
  task automatic apply(input bit r, input bit cb, input bit te, input bit fe, input bit orb);
    @(negedge CLK);
    rst_b = r; calib_busy = cb; test_enable = te; fifo_empty = fe; orbit = orb;
    model_step(r, cb, te, fe, orb);
    exp_q.push_back(mode_outputs(m_mode, m_flag));
  endtask

  task automatic hold(input bit r, input bit cb, input bit te, input bit fe, input int n);
    for (int i = 0; i < n; i++) apply(r, cb, te, fe, 1'b0);
  endtask

  // Monitor: every rising edge the DUT presents a new output word.
  initial begin
    logic [6:0] act, expv;
    forever begin
      @(posedge CLK);
      #1;
      cyc++;
      if (exp_q.size() != 0) begin
        expv = exp_q.pop_front();
        act  = {state_o, dp_rst_b, enc_enable, sel_atu, drain_timeout};
        n_tests++;
        if (act !== expv) begin
          n_fail++;
          $display("FAIL outputs cyc=%0d act st=%0d dp=%b en=%b sel=%b dto=%b req st=%0d dp=%b en=%b sel=%b dto=%b",
                   cyc, act[6:4], act[3], act[2], act[1], act[0],
                   expv[6:4], expv[3], expv[2], expv[1], expv[0]);
        end
      end
    end
  end

  // Stimulus: directed scenarios then randomized traffic.
  initial begin
    bit cb, te, fe, orb, r;
    int fe_pct;
    // bring-up
    hold(1'b0, 0, 0, 0, 3);
    hold(1'b1, 0, 0, 0, 8);
    // drain into test: 10 non-empty cycles then empty
    hold(1'b1, 0, 1, 0, 10);
    hold(1'b1, 0, 1, 1, 8);
    // back to run
    hold(1'b1, 0, 0, 0, 8);
    // drain timeout into calib, then CALIB -> RESET -> RUN with the flag sticky
    hold(1'b1, 1, 0, 0, 70);
    hold(1'b1, 0, 0, 0, 10);
    // priority: both requests on one edge
    hold(1'b1, 1, 1, 0, 3);
    hold(1'b1, 1, 1, 1, 4);
    hold(1'b1, 0, 1, 1, 8);
    hold(1'b1, 0, 0, 0, 8);
    // reset mid-drain
    hold(1'b1, 0, 1, 0, 21);
    hold(1'b0, 0, 1, 0, 1);
    hold(1'b1, 0, 0, 0, 8);
    // orbit pulse some cycles after release
    hold(1'b0, 0, 0, 0, 1);
    hold(1'b1, 0, 0, 0, 13);
    apply(1'b1, 0, 0, 0, 1'b1);
    hold(1'b1, 0, 0, 0, 4);
    // randomized traffic with persistent requests
    cb = 0; te = 0;
    for (int blk = 0; blk < 6; blk++) begin
      fe_pct = (blk % 2 == 0) ? 4 : 30;
      for (int i = 0; i < 500; i++) begin
        if ($urandom_range(0, 39) == 0) cb = ~cb;
        if ($urandom_range(0, 29) == 0) te = ~te;
        fe  = ($urandom_range(0, 99) < fe_pct);
        orb = ($urandom_range(0, 19) == 0);
        r   = ($urandom_range(0, 299) != 0);
        apply(r, cb, te, fe, orb);
      end
    end
    hold(1'b1, 0, 0, 1, 3);
    @(negedge CLK);
    @(negedge CLK);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_queue act %0d pending req 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    stim_done = 1'b1;
    $finish;
  end

  // Overall time bound.
  initial begin
    #1000000;
    if (!stim_done) begin
      n_fail++;
      $display("FAIL watchdog act running req finished");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog expired");
    end
  end

endmodule
